// File: rtl/ram_sdp16_pkg.sv
// +----------------------------------------------------------------------------+
// | ram_sdp16_pkg : shared geometry of the UART-to-TFT frame buffer RAM        |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package ram_sdp16_pkg;

  localparam int c_addr_w = 16;
  localparam int c_data_w = 16;
  localparam int c_depth  = 2 ** c_addr_w;

endpackage

`default_nettype wire

// File: rtl/ram_sdp16_array.sv
// +----------------------------------------------------------------------------+
// | ram_sdp16_array : bare storage array, sync write, registered read-first    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_sdp16_array
  import ram_sdp16_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int c_words = 2 ** ADDR_W;

  // No reset on the array or its read register, so the tools can map both
  // straight into a block RAM primitive.
  logic [DATA_W-1:0] r_mem [0:c_words-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read of the same edge gives the old word on a collision.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ram_sdp16.sv
// +----------------------------------------------------------------------------+
// | ram_sdp16 : 64K x 16 simple dual-port RAM, port A write, port B read       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_sdp16
  import ram_sdp16_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [0:0]        wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic              r_vld;

  assign w_we = ena & wea[0];

  ram_sdp16_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (addra),
    .i_wdata (dina),
    .i_re    (enb),
    .i_raddr (addrb),
    .o_rdata (w_rdata)
  );

  // The block-RAM output register cannot take an async clear, so a reset
  // flag masks it until the first read after reset refreshes its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
    end else if (enb) begin
      r_vld <= 1'b1;
    end
  end

  assign doutb = r_vld ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_sdp16.sv
// +----------------------------------------------------------------------------+
// | tb_ram_sdp16 : directed bench with an array-level reference model          |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_sdp16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [0:0]  wea;
  logic [15:0] addra;
  logic [15:0] dina;
  logic        enb;
  logic [15:0] addrb;
  logic [15:0] doutb;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference: plain memory plus the word port B must be showing.
  logic [15:0] mdl_mem [0:65535];
  logic [15:0] mdl_exp = 16'h0000;

  ram_sdp16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_exp = 16'h0000;
    end else begin
      if (enb) mdl_exp = mdl_mem[addrb];
      if (ena && wea[0]) mdl_mem[addra] = dina;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (doutb !== mdl_exp) begin
        n_err++;
        $display("FAIL model_cmp t=%0t doutb=%h expected=%h", $time, doutb, mdl_exp);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] exp);
    n_vec++;
    if (doutb !== exp) begin
      n_err++;
      $display("FAIL %s doutb=%h expected=%h", name, doutb, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) mdl_mem[k] = 16'h0000;
    rst_n = 1'b0;
    ena   = 1'b0;
    wea   = 1'b0;
    addra = 16'h0000;
    dina  = 16'h0000;
    enb   = 1'b1;
    addrb = 16'h0000;

    // Reset with reads requested, then a read of never-written address 0
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_dout", 16'h0000);
    rst_n = 1'b1;
    tick();
    check("first_read_zero", 16'h0000);

    // Fill every word with its own address while reading the previous one
    for (int i = 0; i <= 65536; i++) begin
      ena   = (i < 65536);
      wea   = (i < 65536);
      addra = i[15:0];
      dina  = i[15:0];
      enb   = (i > 0);
      addrb = 16'(i - 1);
      tick();
      if (i == 32'h1235)  check("fill_1234", 16'h1234);
      if (i == 32'h10000) check("fill_ffff", 16'hFFFF);
    end

    // Gated writes must not land
    ena = 1'b1; wea = 1'b0; addra = 16'h0010; dina = 16'hBEEF; enb = 1'b0;
    tick();
    ena = 1'b0; wea = 1'b1;
    tick();
    wea = 1'b0; enb = 1'b1; addrb = 16'h0010;
    tick();
    check("gated_write", 16'h0010);

    // Output holds while enb is low
    addrb = 16'h00AA;
    tick();
    check("read_aa", 16'h00AA);
    enb = 1'b0; addrb = 16'h0055;
    tick();
    tick();
    check("read_hold", 16'h00AA);

    // Read-first collision
    ena = 1'b1; wea = 1'b1; addra = 16'h0100; dina = 16'hCAFE;
    enb = 1'b1; addrb = 16'h0100;
    tick();
    check("collision_old", 16'h0100);
    ena = 1'b0; wea = 1'b0;
    tick();
    check("collision_new", 16'hCAFE);

    // Asynchronous reset pulse between edges
    #1 rst_n = 1'b0;
    #1 check("async_clear", 16'h0000);
    #1 rst_n = 1'b1;
    enb = 1'b0;
    tick();
    check("reset_drops_read", 16'h0000);
    enb = 1'b1; addrb = 16'h0100;
    tick();
    check("mem_kept_cafe", 16'hCAFE);
    addrb = 16'hFFFF;
    tick();
    check("mem_kept_ffff", 16'hFFFF);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
